// File: rtl/calc1_port_driver_pkg.sv
// ---------------------------------------------------------------------------
// calc1_port_driver_pkg
//  Shared encodings for the calc1 port driver: command codes, response codes,
//  driver FSM states and the legal-command check used for local rejection.
// ---------------------------------------------------------------------------
package calc1_port_driver_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;
   localparam logic [1:0] RESP_TMO  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND1,
      ST_SEND2,
      ST_WAIT_RESP,
      ST_HOLD
   } state_t;

   // True for the four operations calc1 actually implements.
   function automatic logic cmd_is_legal(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
             (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

endpackage

// File: rtl/calc1_port_driver_if.sv
// ---------------------------------------------------------------------------
// calc1_port_driver_if
//  Bundles the upstream request handshake, the calc1 port wires and the
//  downstream response handshake of one calc1 port driver.
//  master : driver side (drives req_ready, calc_cmd/data, rsp_*, spurious)
//  slave  : environment side (drives req_*, calc_resp/rdata, rsp_ready)
// ---------------------------------------------------------------------------
interface calc1_port_driver_if;

   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cmd;
   logic [31:0] req_op1;
   logic [31:0] req_op2;
   logic [3:0]  calc_cmd;
   logic [31:0] calc_data;
   logic [1:0]  calc_resp;
   logic [31:0] calc_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_resp;
   logic [31:0] rsp_data;
   logic        spurious;

   modport master (
      input  req_valid, req_cmd, req_op1, req_op2,
      input  calc_resp, calc_rdata, rsp_ready,
      output req_ready, calc_cmd, calc_data,
      output rsp_valid, rsp_resp, rsp_data, spurious
   );

   modport slave (
      output req_valid, req_cmd, req_op1, req_op2,
      output calc_resp, calc_rdata, rsp_ready,
      input  req_ready, calc_cmd, calc_data,
      input  rsp_valid, rsp_resp, rsp_data, spurious
   );

endinterface

// File: rtl/calc1_port_driver_resp_timer.sv
// ---------------------------------------------------------------------------
// calc1_resp_timer
//  8-bit response wait counter for the calc1 port driver.
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : zero the count
//  enable     : count one more cycle without a response
//  expired    : this enabled cycle brings the count to TIMEOUT
// ---------------------------------------------------------------------------
module calc1_resp_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   // Saturate so a stuck enable can never wrap back into a fresh window.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The count value during the k-th empty wait cycle is k-1, so the
   // TIMEOUT-th empty cycle is the one that sees LAST.
   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/calc1_port_driver.sv
// ---------------------------------------------------------------------------
// calc1_port_driver
//  Accepts one (cmd, op1, op2) operation, serialises it onto a calc1 request
//  port over two cycles, waits for calc1's answer (or times out) and holds
//  {resp, data} on a valid/ready response handshake.
//  c_clk    : clock
//  reset_n  : asynchronous active-low reset
//  bus      : calc1_port_driver_if.master (req_*, calc_*, rsp_*, spurious)
// ---------------------------------------------------------------------------
module calc1_port_driver
   import calc1_port_driver_pkg::*;
#(
   parameter int TIMEOUT   = 16,
   parameter bit CHECK_CMD = 1'b1
) (
   input logic                  c_clk,
   input logic                  reset_n,
   calc1_port_driver_if.master  bus
);

   state_t      state_q, state_d;
   logic [31:0] op2_q, op2_d;
   logic        req_ready_q, req_ready_d;
   logic [3:0]  calc_cmd_q, calc_cmd_d;
   logic [31:0] calc_data_q, calc_data_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [1:0]  rsp_resp_q, rsp_resp_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        spurious_q, spurious_d;
   logic        tmr_clear, tmr_enable, tmr_expired;

   calc1_resp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (c_clk),
      .rst_n   (reset_n),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   // Every output is a register loaded with the value belonging to the
   // next state, so the port wires change on the same edge as the state.
   // cmd and op1 go straight into the SEND1 output registers on accept;
   // only op2 needs its own holding register until SEND2.
   always_comb begin
      state_d     = state_q;
      op2_d       = op2_q;
      calc_cmd_d  = CMD_NOP;
      calc_data_d = '0;
      rsp_resp_d  = rsp_resp_q;
      rsp_data_d  = rsp_data_q;
      spurious_d  = (bus.calc_resp != RESP_NONE) && (state_q != ST_WAIT_RESP);
      tmr_clear   = 1'b0;
      tmr_enable  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op2_d = bus.req_op2;
               if (CHECK_CMD && !cmd_is_legal(bus.req_cmd)) begin
                  state_d    = ST_HOLD;
                  rsp_resp_d = RESP_ERR;
                  rsp_data_d = '0;
               end else begin
                  state_d     = ST_SEND1;
                  calc_cmd_d  = bus.req_cmd;
                  calc_data_d = bus.req_op1;
               end
            end
         end
         ST_SEND1: begin
            state_d     = ST_SEND2;
            calc_data_d = op2_q;
         end
         ST_SEND2: begin
            state_d   = ST_WAIT_RESP;
            tmr_clear = 1'b1;
         end
         ST_WAIT_RESP: begin
            // A response beats a timeout landing in the same cycle.
            if (bus.calc_resp != RESP_NONE) begin
               state_d    = ST_HOLD;
               rsp_resp_d = bus.calc_resp;
               rsp_data_d = (bus.calc_resp == RESP_OK) ? bus.calc_rdata : '0;
            end else begin
               tmr_enable = 1'b1;
               if (tmr_expired) begin
                  state_d    = ST_HOLD;
                  rsp_resp_d = RESP_TMO;
                  rsp_data_d = '0;
               end
            end
         end
         ST_HOLD: begin
            if (bus.rsp_ready) begin
               state_d    = ST_IDLE;
               rsp_resp_d = RESP_NONE;
               rsp_data_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rsp_valid_d = (state_d == ST_HOLD);
      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op2_q       <= '0;
         req_ready_q <= 1'b1;
         calc_cmd_q  <= CMD_NOP;
         calc_data_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_resp_q  <= RESP_NONE;
         rsp_data_q  <= '0;
         spurious_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op2_q       <= op2_d;
         req_ready_q <= req_ready_d;
         calc_cmd_q  <= calc_cmd_d;
         calc_data_q <= calc_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_data_q  <= rsp_data_d;
         spurious_q  <= spurious_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.calc_cmd  = calc_cmd_q;
   assign bus.calc_data = calc_data_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_resp  = rsp_resp_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.spurious  = spurious_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// ---------------------------------------------------------------------------
// tb_calc1_port_driver
//  Two drivers share one stimulus source: dut_a rejects illegal commands
//  locally, dut_b forwards everything to calc1. sel_b picks which one gets
//  req_valid and whose outputs are observed. calc1 itself is played by the
//  bench: it answers once, a chosen number of wait cycles after SEND2.
// ---------------------------------------------------------------------------
module tb_calc1_port_driver;

   localparam int TMO = 16;

   logic        c_clk = 1'b0;
   logic        reset_n;
   logic        sel_b;
   logic        req_valid;
   logic [3:0]  req_cmd;
   logic [31:0] req_op1, req_op2;
   logic        rsp_ready;
   logic [1:0]  calc_resp;
   logic [31:0] calc_rdata;

   int checks = 0;
   int errors = 0;

   // Observations filled in by send_op
   logic [3:0]  obs_cmd1, obs_cmd2;
   logic [31:0] obs_data1, obs_data2, obs_data;
   logic [1:0]  obs_resp;
   int          obs_lat;
   bit          obs_any_cmd, obs_bound;

   always #5 c_clk = ~c_clk;

   calc1_port_driver_if bus_a ();
   calc1_port_driver_if bus_b ();

   // Shared stimulus, req_valid steered by sel_b
   assign bus_a.req_valid  = req_valid & ~sel_b;
   assign bus_b.req_valid  = req_valid & sel_b;
   assign bus_a.req_cmd    = req_cmd;
   assign bus_b.req_cmd    = req_cmd;
   assign bus_a.req_op1    = req_op1;
   assign bus_b.req_op1    = req_op1;
   assign bus_a.req_op2    = req_op2;
   assign bus_b.req_op2    = req_op2;
   assign bus_a.rsp_ready  = rsp_ready;
   assign bus_b.rsp_ready  = rsp_ready;
   assign bus_a.calc_resp  = calc_resp;
   assign bus_b.calc_resp  = calc_resp;
   assign bus_a.calc_rdata = calc_rdata;
   assign bus_b.calc_rdata = calc_rdata;

   // Observed outputs of the selected driver
   logic        o_req_ready, o_rsp_valid, o_spurious;
   logic [3:0]  o_calc_cmd;
   logic [31:0] o_calc_data, o_rsp_data;
   logic [1:0]  o_rsp_resp;
   assign o_req_ready = sel_b ? bus_b.req_ready : bus_a.req_ready;
   assign o_rsp_valid = sel_b ? bus_b.rsp_valid : bus_a.rsp_valid;
   assign o_spurious  = sel_b ? bus_b.spurious  : bus_a.spurious;
   assign o_calc_cmd  = sel_b ? bus_b.calc_cmd  : bus_a.calc_cmd;
   assign o_calc_data = sel_b ? bus_b.calc_data : bus_a.calc_data;
   assign o_rsp_resp  = sel_b ? bus_b.rsp_resp  : bus_a.rsp_resp;
   assign o_rsp_data  = sel_b ? bus_b.rsp_data  : bus_a.rsp_data;

   calc1_port_driver #(.TIMEOUT(TMO), .CHECK_CMD(1'b1)) dut_a (
      .c_clk   (c_clk),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   calc1_port_driver #(.TIMEOUT(TMO), .CHECK_CMD(1'b0)) dut_b (
      .c_clk   (c_clk),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   // What calc1 answers for an operation
   function automatic void calc1_model(input logic [3:0] cmd, input logic [31:0] a,
                                       input logic [31:0] b, output logic [1:0] r,
                                       output logic [31:0] v);
      logic [32:0] s;
      r = 2'd2;
      v = 32'd0;
      case (cmd)
         4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[32] ? 2'd2 : 2'd1; v = s[31:0]; end
         4'd2: begin r = (a < b) ? 2'd2 : 2'd1; v = a - b; end
         4'd5: begin r = (b[31:5] != 27'd0) ? 2'd2 : 2'd1; v = a << b[4:0]; end
         4'd6: begin r = (b[31:5] != 27'd0) ? 2'd2 : 2'd1; v = a >> b[4:0]; end
         default: r = 2'd2;
      endcase
   endfunction

   // Presents one operation, plays calc1 (answer during wait cycle 'lat'
   // when respond=1) and records what the driver showed, edge by edge,
   // until rsp_valid appears. k counts clock edges after the accept edge.
   task automatic send_op(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input bit respond, input int lat, input logic [1:0] cresp,
                          input logic [31:0] crdata);
      int guard;
      int k;
      obs_any_cmd = 1'b0;
      obs_bound   = 1'b0;
      obs_lat     = -1;
      @(posedge c_clk); #1;
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_op1   = op1;
      req_op2   = op2;
      guard = 0;
      while (o_req_ready !== 1'b1 && guard < 50) begin
         @(posedge c_clk); #1;
         guard++;
      end
      if (guard >= 50) obs_bound = 1'b1;
      @(posedge c_clk); #1;
      req_valid = 1'b0;
      req_cmd   = 4'($urandom);
      req_op1   = $urandom;
      req_op2   = $urandom;
      for (k = 0; k < 60; k++) begin
         if (k > 0) begin
            @(posedge c_clk); #1;
         end
         if (respond && k == 2 + lat) begin
            calc_resp  = cresp;
            calc_rdata = crdata;
         end else begin
            calc_resp  = 2'd0;
            calc_rdata = $urandom;
         end
         @(negedge c_clk);
         if (k == 0) begin
            obs_cmd1  = o_calc_cmd;
            obs_data1 = o_calc_data;
         end
         if (k == 1) begin
            obs_cmd2  = o_calc_cmd;
            obs_data2 = o_calc_data;
         end
         if (o_calc_cmd != 4'd0) obs_any_cmd = 1'b1;
         if (o_rsp_valid === 1'b1) begin
            obs_lat  = k;
            obs_resp = o_rsp_resp;
            obs_data = o_rsp_data;
            break;
         end
      end
      if (k >= 60) obs_bound = 1'b1;
      calc_resp = 2'd0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(posedge c_clk);
      @(negedge c_clk);
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", o_req_ready); end
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", o_rsp_valid); end
      checks++; if (o_calc_cmd !== 4'd0) begin errors++; $display("[TB] FAIL reset_calc_cmd got %h want 0", o_calc_cmd); end
      checks++; if (o_calc_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_calc_data got %h want 0", o_calc_data); end
      checks++; if (o_rsp_resp !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_resp got %h want 0", o_rsp_resp); end
      checks++; if (o_rsp_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp_data got %h want 0", o_rsp_data); end
      checks++; if (o_spurious !== 1'b0) begin errors++; $display("[TB] FAIL reset_spurious got %b want 0", o_spurious); end
      @(posedge c_clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_add;
      sel_b = 1'b0; rsp_ready = 1'b1;
      send_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 1'b1, 0, 2'd1, 32'h0200_0000);
      checks++; if (obs_bound !== 1'b0) begin errors++; $display("[TB] FAIL add_bound got %b want 0", obs_bound); end
      checks++; if (obs_cmd1 !== 4'd1) begin errors++; $display("[TB] FAIL add_send1_cmd got %h want 1", obs_cmd1); end
      checks++; if (obs_data1 !== 32'h1) begin errors++; $display("[TB] FAIL add_send1_data got %h want 1", obs_data1); end
      checks++; if (obs_cmd2 !== 4'd0) begin errors++; $display("[TB] FAIL add_send2_cmd got %h want 0", obs_cmd2); end
      checks++; if (obs_data2 !== 32'h01FF_FFFF) begin errors++; $display("[TB] FAIL add_send2_data got %h want 01ffffff", obs_data2); end
      checks++; if (obs_lat !== 3) begin errors++; $display("[TB] FAIL add_latency got %0d want 3", obs_lat); end
      checks++; if (obs_resp !== 2'd1) begin errors++; $display("[TB] FAIL add_resp got %h want 1", obs_resp); end
      checks++; if (obs_data !== 32'h0200_0000) begin errors++; $display("[TB] FAIL add_data got %h want 02000000", obs_data); end
      @(posedge c_clk); @(negedge c_clk);
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_valid_drop got %b want 0", o_rsp_valid); end
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready_back got %b want 1", o_req_ready); end
   endtask

   task automatic test_errors;
      sel_b = 1'b0; rsp_ready = 1'b1;
      send_op(4'd1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1, 2'd2, 32'hDEAD_BEEF);
      checks++; if (obs_resp !== 2'd2) begin errors++; $display("[TB] FAIL ovf_resp got %h want 2", obs_resp); end
      checks++; if (obs_data !== 32'd0) begin errors++; $display("[TB] FAIL ovf_data got %h want 0", obs_data); end
      checks++; if (obs_lat !== 4) begin errors++; $display("[TB] FAIL ovf_latency got %0d want 4", obs_lat); end
      @(posedge c_clk); @(negedge c_clk);
      send_op(4'd2, 32'h1, 32'hF, 1'b1, 3, 2'd2, 32'hFFFF_FFF2);
      checks++; if (obs_resp !== 2'd2) begin errors++; $display("[TB] FAIL unf_resp got %h want 2", obs_resp); end
      checks++; if (obs_data !== 32'd0) begin errors++; $display("[TB] FAIL unf_data got %h want 0", obs_data); end
      checks++; if (obs_lat !== 6) begin errors++; $display("[TB] FAIL unf_latency got %0d want 6", obs_lat); end
      @(posedge c_clk); @(negedge c_clk);
   endtask

   task automatic test_illegal;
      sel_b = 1'b0; rsp_ready = 1'b1;
      send_op(4'd3, 32'h1234, 32'h5678, 1'b1, 2, 2'd1, 32'h1);
      checks++; if (obs_lat !== 0) begin errors++; $display("[TB] FAIL rej_latency got %0d want 0", obs_lat); end
      checks++; if (obs_resp !== 2'd2) begin errors++; $display("[TB] FAIL rej_resp got %h want 2", obs_resp); end
      checks++; if (obs_data !== 32'd0) begin errors++; $display("[TB] FAIL rej_data got %h want 0", obs_data); end
      checks++; if (obs_any_cmd !== 1'b0) begin errors++; $display("[TB] FAIL rej_calc_cmd got %b want 0", obs_any_cmd); end
      @(posedge c_clk); @(negedge c_clk);
      checks++; if (o_calc_cmd !== 4'd0) begin errors++; $display("[TB] FAIL rej_calc_cmd_after got %h want 0", o_calc_cmd); end
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rej_ready_back got %b want 1", o_req_ready); end
      // Same command on the driver that forwards everything
      sel_b = 1'b1;
      send_op(4'd3, 32'h1234, 32'h5678, 1'b1, 2, 2'd2, 32'hCAFE_0000);
      checks++; if (obs_cmd1 !== 4'd3) begin errors++; $display("[TB] FAIL fwd_send1_cmd got %h want 3", obs_cmd1); end
      checks++; if (obs_lat !== 5) begin errors++; $display("[TB] FAIL fwd_latency got %0d want 5", obs_lat); end
      checks++; if (obs_resp !== 2'd2) begin errors++; $display("[TB] FAIL fwd_resp got %h want 2", obs_resp); end
      checks++; if (obs_data !== 32'd0) begin errors++; $display("[TB] FAIL fwd_data got %h want 0", obs_data); end
      @(posedge c_clk); @(negedge c_clk);
      sel_b = 1'b0;
   endtask

   task automatic test_timeout;
      sel_b = 1'b0; rsp_ready = 1'b1;
      send_op(4'd1, 32'd5, 32'd6, 1'b0, 0, 2'd0, 32'd0);
      checks++; if (obs_lat !== 2 + TMO) begin errors++; $display("[TB] FAIL tmo_latency got %0d want %0d", obs_lat, 2 + TMO); end
      checks++; if (obs_resp !== 2'd3) begin errors++; $display("[TB] FAIL tmo_resp got %h want 3", obs_resp); end
      checks++; if (obs_data !== 32'd0) begin errors++; $display("[TB] FAIL tmo_data got %h want 0", obs_data); end
      @(posedge c_clk); @(negedge c_clk);
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL tmo_ready_back got %b want 1", o_req_ready); end
      // Answer in the very cycle the count reaches TIMEOUT: the answer wins
      send_op(4'd2, 32'd100, 32'd30, 1'b1, TMO - 1, 2'd1, 32'd70);
      checks++; if (obs_lat !== 2 + TMO) begin errors++; $display("[TB] FAIL race_latency got %0d want %0d", obs_lat, 2 + TMO); end
      checks++; if (obs_resp !== 2'd1) begin errors++; $display("[TB] FAIL race_resp got %h want 1", obs_resp); end
      checks++; if (obs_data !== 32'd70) begin errors++; $display("[TB] FAIL race_data got %h want 46", obs_data); end
      @(posedge c_clk); @(negedge c_clk);
   endtask

   task automatic test_backpressure;
      logic [1:0]  held_resp;
      logic [31:0] held_data;
      sel_b = 1'b0; rsp_ready = 1'b0;
      send_op(4'd5, 32'h0000_00F0, 32'd4, 1'b1, 2, 2'd1, 32'h0000_0F00);
      held_resp = obs_resp;
      held_data = obs_data;
      checks++; if (held_data !== 32'h0000_0F00) begin errors++; $display("[TB] FAIL bp_data got %h want 00000f00", held_data); end
      for (int i = 0; i < 10; i++) begin
         @(posedge c_clk); @(negedge c_clk);
         checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_%0d got %b want 1", i, o_rsp_valid); end
         checks++; if (o_rsp_resp !== 2'd1) begin errors++; $display("[TB] FAIL bp_resp_%0d got %h want 1", i, o_rsp_resp); end
         checks++; if (o_rsp_data !== 32'h0000_0F00) begin errors++; $display("[TB] FAIL bp_stable_%0d got %h want 00000f00", i, o_rsp_data); end
         checks++; if (o_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_ready_%0d got %b want 0", i, o_req_ready); end
      end
      rsp_ready = 1'b1;
      @(posedge c_clk); @(negedge c_clk);
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got %b want 0", o_rsp_valid); end
      @(posedge c_clk); @(negedge c_clk);
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_single_transfer got %b want 0", o_rsp_valid); end
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back got %b want 1", o_req_ready); end
   endtask

   task automatic test_reset_mid_op;
      sel_b = 1'b0; rsp_ready = 1'b1;
      @(posedge c_clk); #1;
      req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'd3; req_op2 = 32'd4;
      @(posedge c_clk); #1;
      req_valid = 1'b0;
      repeat (6) @(posedge c_clk);
      #1 reset_n = 1'b0;
      #1;
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_req_ready got %b want 1", o_req_ready); end
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_rsp_valid got %b want 0", o_rsp_valid); end
      checks++; if (o_calc_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_calc_data got %h want 0", o_calc_data); end
      checks++; if (o_rsp_resp !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_rsp_resp got %h want 0", o_rsp_resp); end
      @(posedge c_clk); #1;
      reset_n = 1'b1;
      @(posedge c_clk); #1;
      calc_resp = 2'd1; calc_rdata = 32'd7;
      @(posedge c_clk); #1;
      calc_resp = 2'd0;
      @(negedge c_clk);
      checks++; if (o_spurious !== 1'b1) begin errors++; $display("[TB] FAIL late_spurious got %b want 1", o_spurious); end
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_rsp_valid got %b want 0", o_rsp_valid); end
      @(posedge c_clk); @(negedge c_clk);
      checks++; if (o_spurious !== 1'b0) begin errors++; $display("[TB] FAIL late_spurious_pulse got %b want 0", o_spurious); end
      for (int i = 0; i < 4; i++) begin
         @(posedge c_clk); @(negedge c_clk);
         checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_no_rsp_%0d got %b want 0", i, o_rsp_valid); end
      end
      checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL late_req_ready got %b want 1", o_req_ready); end
   endtask

   task automatic test_back_to_back;
      logic [3:0]  cmd;
      logic [31:0] op1, op2, m_val, exp_data;
      logic [1:0]  m_resp, exp_resp;
      int          lat, exp_lat, idle;
      bit          respond, rejected;
      for (int n = 0; n < 20; n++) begin
         sel_b = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: cmd = 4'd1;
            1: cmd = 4'd2;
            2: cmd = 4'd5;
            3: cmd = 4'd6;
            4: cmd = 4'd3;
            default: cmd = 4'd9;
         endcase
         op1 = (n % 4 == 1) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : $urandom;
         op2 = (n % 3 == 0) ? $urandom : 32'($urandom_range(0, 40));
         lat = $urandom_range(0, 12);
         respond = ($urandom_range(0, 5) != 0);
         rsp_ready = 1'($urandom_range(0, 1));
         calc1_model(cmd, op1, op2, m_resp, m_val);
         send_op(cmd, op1, op2, respond, lat, m_resp, (m_resp == 2'd1) ? m_val : $urandom);
         rejected = !sel_b && !(cmd == 4'd1 || cmd == 4'd2 || cmd == 4'd5 || cmd == 4'd6);
         if (rejected) begin
            exp_lat = 0; exp_resp = 2'd2; exp_data = 32'd0;
         end else if (!respond) begin
            exp_lat = 2 + TMO; exp_resp = 2'd3; exp_data = 32'd0;
         end else begin
            exp_lat = 3 + lat; exp_resp = m_resp; exp_data = (m_resp == 2'd1) ? m_val : 32'd0;
         end
         checks++; if (obs_bound !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_bound got %b want 0", n, obs_bound); end
         checks++; if (obs_lat !== exp_lat) begin errors++; $display("[TB] FAIL rnd%0d_latency got %0d want %0d", n, obs_lat, exp_lat); end
         checks++; if (obs_resp !== exp_resp) begin errors++; $display("[TB] FAIL rnd%0d_resp got %h want %h", n, obs_resp, exp_resp); end
         checks++; if (obs_data !== exp_data) begin errors++; $display("[TB] FAIL rnd%0d_data got %h want %h", n, obs_data, exp_data); end
         if (!rejected) begin
            checks++; if (obs_cmd1 !== cmd) begin errors++; $display("[TB] FAIL rnd%0d_send1_cmd got %h want %h", n, obs_cmd1, cmd); end
            checks++; if (obs_data1 !== op1) begin errors++; $display("[TB] FAIL rnd%0d_send1_data got %h want %h", n, obs_data1, op1); end
            checks++; if (obs_cmd2 !== 4'd0) begin errors++; $display("[TB] FAIL rnd%0d_send2_cmd got %h want 0", n, obs_cmd2); end
            checks++; if (obs_data2 !== op2) begin errors++; $display("[TB] FAIL rnd%0d_send2_data got %h want %h", n, obs_data2, op2); end
         end else begin
            checks++; if (obs_any_cmd !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_rej_calc_cmd got %b want 0", n, obs_any_cmd); end
         end
         if (!rsp_ready) begin
            idle = $urandom_range(1, 4);
            for (int i = 0; i < idle; i++) begin
               @(posedge c_clk); @(negedge c_clk);
               checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_hold got %b want 1", n, o_rsp_valid); end
            end
            rsp_ready = 1'b1;
         end
         @(posedge c_clk); @(negedge c_clk);
         checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_valid_drop got %b want 0", n, o_rsp_valid); end
         checks++; if (o_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_ready_back got %b want 1", n, o_req_ready); end
      end
      sel_b = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      sel_b      = 1'b0;
      req_valid  = 1'b0;
      req_cmd    = 4'd0;
      req_op1    = 32'd0;
      req_op2    = 32'd0;
      rsp_ready  = 1'b1;
      calc_resp  = 2'd0;
      calc_rdata = 32'd0;
      test_reset;
      test_add;
      test_errors;
      test_illegal;
      test_timeout;
      test_backpressure;
      test_reset_mid_op;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
